uart_bps_gen: RTL and testbench



---
 rtl/uart_bps_gen.sv | 107 ++++++++++
 tb/tb_uart_bps_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_bps_gen.sv
// UART baud-rate generator: runtime-selectable divisor, mid-bit sample strobe,
// bit-boundary strobe, bit index and end-of-frame strobe.
module uart_bps_gen #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned DIV_9600   = 5207,
  parameter int unsigned DIV_19200  = 2603,
  parameter int unsigned DIV_38400  = 1301,
  parameter int unsigned DIV_57600  = 867,
  parameter int unsigned DIV_115200 = 433
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_start,
  input  logic [2:0]       baud_sel,
  input  logic [DIV_W-1:0] div_custom,
  output logic             bps_sig,
  output logic             bit_end,
  output logic [3:0]       bit_idx,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_q, div_nxt, div_sel, mid;
  logic [3:0]       idx_nxt;
  logic             run_ok, last_bit, at_end;

  always_comb begin
    div_sel = DIV_W'(DIV_9600);
    case (baud_sel)
      3'd0:    div_sel = DIV_W'(DIV_9600);
      3'd1:    div_sel = DIV_W'(DIV_19200);
      3'd2:    div_sel = DIV_W'(DIV_38400);
      3'd3:    div_sel = DIV_W'(DIV_57600);
      3'd4:    div_sel = DIV_W'(DIV_115200);
      3'd7:    div_sel = (div_custom < DIV_W'(3)) ? DIV_W'(3) : div_custom;
      default: div_sel = DIV_W'(DIV_9600);
    endcase
  end

  // (div_q+1)>>1 rewritten as div_q/2 + lsb so it cannot overflow DIV_W bits
  assign mid      = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
  assign last_bit = (bit_idx == 4'(FRAME_BITS - 1));
  assign at_end   = (cnt == div_q);

  // Dropping cnt_start suppresses every strobe in that same cycle
  assign run_ok     = (state == RUN) && cnt_start;
  assign bps_sig    = run_ok && (cnt == mid);
  assign bit_end    = run_ok && at_end;
  assign frame_done = bit_end && last_bit;
  assign busy       = (state == RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_q;
    idx_nxt   = bit_idx;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (cnt_start) begin
          state_nxt = RUN;
          cnt_nxt   = DIV_W'(1);
          div_nxt   = div_sel;
        end
      end
      RUN: begin
        if (!cnt_start) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (at_end) begin
          cnt_nxt = '0;
          if (last_bit) begin
            idx_nxt = '0;
            div_nxt = div_sel;
          end else begin
            idx_nxt = bit_idx + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= DIV_W'(DIV_9600);
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_q   <= div_nxt;
      bit_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_bps_gen.sv
// Checks two generator instances (10-bit and 2-bit frames) against a
// tick-within-frame reference model under directed and random stimulus.
module tb_uart_bps_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_start = 1'b0;
  logic [2:0]  baud_sel = 3'd0;
  logic [15:0] div_custom = 16'd0;

  logic        bps_w[2];
  logic        end_w[2];
  logic [3:0]  idx_w[2];
  logic        fd_w[2];
  logic        busy_w[2];

  int checks = 0;
  int failures = 0;

  // model: running flag, tick within current frame, latched divisor-1
  int m_run[2];
  int m_k[2];
  int m_div[2];
  int fb[2] = '{10, 2};

  always #5 clk = ~clk;

  uart_bps_gen #(.FRAME_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .baud_sel(baud_sel),
    .div_custom(div_custom), .bps_sig(bps_w[0]), .bit_end(end_w[0]),
    .bit_idx(idx_w[0]), .frame_done(fd_w[0]), .busy(busy_w[0])
  );

  uart_bps_gen #(.FRAME_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .baud_sel(baud_sel),
    .div_custom(div_custom), .bps_sig(bps_w[1]), .bit_end(end_w[1]),
    .bit_idx(idx_w[1]), .frame_done(fd_w[1]), .busy(busy_w[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int sel_div(input logic [2:0] sel, input logic [15:0] cust);
    case (sel)
      3'd1: return 2603;
      3'd2: return 1301;
      3'd3: return 867;
      3'd4: return 433;
      3'd7: return (cust < 3) ? 3 : int'(cust);
      default: return 5207;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_k[i] = 0; m_div[i] = 5207;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int flen;
      flen = fb[i] * (m_div[i] + 1);
      if (m_run[i] == 0) begin
        if (cnt_start) begin
          m_run[i] = 1; m_k[i] = 1; m_div[i] = sel_div(baud_sel, div_custom);
        end
      end else if (!cnt_start) begin
        m_run[i] = 0; m_k[i] = 0;
      end else if (m_k[i] == flen - 1) begin
        m_k[i] = 0; m_div[i] = sel_div(baud_sel, div_custom);
      end else begin
        m_k[i]++;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int per, ph;
      bit act;
      per = m_div[i] + 1;
      ph  = m_k[i] % per;
      act = (m_run[i] != 0) && cnt_start && rst_n;
      check($sformatf("bps_sig[%0d]", i), int'(bps_w[i]), int'(act && ph == per / 2));
      check($sformatf("bit_end[%0d]", i), int'(end_w[i]), int'(act && ph == m_div[i]));
      check($sformatf("frame_done[%0d]", i), int'(fd_w[i]),
            int'(act && m_k[i] == fb[i] * per - 1));
      check($sformatf("bit_idx[%0d]", i), int'(idx_w[i]), m_run[i] != 0 ? m_k[i] / per : 0);
      check($sformatf("busy[%0d]", i), int'(busy_w[i]), m_run[i]);
    end
  endtask

  // drive at negedge, check just before the next posedge, then advance model
  task automatic cyc(input bit rn, input bit st, input logic [2:0] sel, input logic [15:0] cust);
    @(negedge clk);
    rst_n = rn; cnt_start = st; baud_sel = sel; div_custom = cust;
    if (!rn) model_reset();
    #4;
    compare();
    @(posedge clk);
    if (rn) model_step();
  endtask

  task automatic run(input int n, input bit st, input logic [2:0] sel, input logic [15:0] cust);
    for (int j = 0; j < n; j++) cyc(1'b1, st, sel, cust);
  endtask

  initial begin
    model_reset();
    // reset held with cnt_start high: everything stays zero
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 3'd0, 16'd0);
    // 9600: one full 10-bit frame plus restart
    run(52100, 1'b1, 3'd0, 16'd0);
    check("after_9600_idx", int'(idx_w[0]), 0);
    run(3, 1'b0, 3'd0, 16'd0);
    // 115200, baud_sel switched to 9600 mid-frame
    run(1000, 1'b1, 3'd4, 16'd0);
    run(1000, 1'b1, 3'd0, 16'd0);
    run(2, 1'b0, 3'd0, 16'd0);
    // custom divisor 1 clamps to 3, then 9
    run(60, 1'b1, 3'd7, 16'd1);
    run(2, 1'b0, 3'd7, 16'd1);
    run(60, 1'b1, 3'd7, 16'd9);
    run(2, 1'b0, 3'd7, 16'd9);
    // abort exactly at mid of bit 3 (tick 35 with period 10)
    run(35, 1'b1, 3'd7, 16'd9);
    @(negedge clk);
    cnt_start = 1'b0;
    #4;
    check("abort_mid_bps", int'(bps_w[0]), 0);
    check("abort_mid_busy_before", int'(busy_w[0]), 1);
    @(posedge clk);
    model_step();
    run(1, 1'b0, 3'd7, 16'd9);
    check("abort_idle_busy", int'(busy_w[0]), 0);
    check("abort_idle_idx", int'(idx_w[0]), 0);
    // 2-bit frame: abort on final bit_end (tick 19), then hold high
    run(19, 1'b1, 3'd7, 16'd9);
    run(2, 1'b0, 3'd7, 16'd9);
    run(60, 1'b1, 3'd7, 16'd9);
    run(2, 1'b0, 3'd7, 16'd9);
    // random phases
    for (int p = 0; p < 60; p++) begin
      logic [2:0]  sel;
      logic [15:0] cust;
      bit st;
      int len;
      case ($urandom_range(0, 5))
        0: sel = 3'd4;
        1: sel = 3'($urandom_range(0, 6));
        default: sel = 3'd7;
      endcase
      cust = 16'($urandom_range(0, 14));
      st   = ($urandom_range(0, 3) != 0);
      len  = $urandom_range(1, 150);
      if ($urandom_range(0, 19) == 0) begin
        cyc(1'b0, st, sel, cust);
      end
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 19) == 0) begin
          sel  = 3'($urandom);
          cust = 16'($urandom_range(0, 14));
        end
        cyc(1'b1, st, sel, cust);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
